// File: rtl/pwm_carrier_sequencer.sv
// pwm_carrier_sequencer
//   Sequences an external PWM carrier generator: arms it after a hold-off,
//   runs it, stops it cleanly at a carrier peak, and latches a fault if the
//   carrier stops producing peak pulses. Divider changes offered while
//   running are held in a shadow register and applied only at a carrier
//   peak, so a carrier period is never cut short.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, stop       run / stop requests (stop wins over start)
//   cfg_valid/ready   divider offer handshake, cfg_freq_div carries the value
//   cfg_err           one-cycle pulse after an illegal divider is refused
//   sync_pulse        carrier peak strobe from the generator
//   fault_clr         leaves FAULT back to IDLE
//   gen_enable        enable to the carrier generator
//   gen_freq_div      active divider to the carrier generator
//   state             IDLE=0, ARM=1, RUN=2, STOPPING=3, FAULT=4
//   fault             high while in FAULT
module pwm_carrier_sequencer #(
  parameter int COUNTER_WIDTH = 16,
  parameter int DEFAULT_DIV   = 10000,
  parameter int MIN_DIV       = 2,
  parameter int ARM_CYCLES    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cfg_valid,
  input  logic [COUNTER_WIDTH-1:0] cfg_freq_div,
  output logic                     cfg_ready,
  output logic                     cfg_err,
  input  logic                     sync_pulse,
  input  logic                     fault_clr,
  output logic                     gen_enable,
  output logic [COUNTER_WIDTH-1:0] gen_freq_div,
  output logic [2:0]               state,
  output logic                     fault
);

  localparam int WD_W  = COUNTER_WIDTH + 2;
  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] DIV_RST = COUNTER_WIDTH'(DEFAULT_DIV);
  localparam logic [COUNTER_WIDTH-1:0] DIV_MIN = COUNTER_WIDTH'(MIN_DIV);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_RUN      = 3'd2,
    S_STOPPING = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t st, st_nxt;

  logic [ARM_W-1:0]         arm_cnt;
  logic [WD_W-1:0]          wd_cnt;
  logic [WD_W-1:0]          wd_inc;
  logic [COUNTER_WIDTH-1:0] shadow_div;
  logic                     shadow_vld;
  logic                     cfg_acc;
  logic                     cfg_legal;
  logic                     wd_expire;
  logic                     carrier_on_nxt;

  // Watchdog limit 2*div+8, formed at the wider watchdog width so the
  // largest divider cannot wrap the limit.
  function automatic logic [WD_W-1:0] wd_limit(input logic [COUNTER_WIDTH-1:0] div);
    logic [WD_W-1:0] wide;
    wide = {2'b00, div};
    return (wide << 1) + WD_W'(8);
  endfunction

  assign cfg_legal = (cfg_freq_div >= DIV_MIN);
  assign cfg_ready = (st == S_IDLE) || ((st == S_RUN) && !shadow_vld);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign wd_inc    = wd_cnt + WD_W'(1);
  // A peak arriving on the expiry cycle rescues the carrier.
  assign wd_expire = !sync_pulse && (wd_inc > wd_limit(gen_freq_div));

  assign carrier_on_nxt = (st_nxt == S_RUN) || (st_nxt == S_STOPPING);
  assign state = st;

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: begin
        if (start && !stop) st_nxt = S_ARM;
      end
      S_ARM: begin
        if (stop)                st_nxt = S_IDLE;
        else if (arm_cnt == '0)  st_nxt = S_RUN;
      end
      S_RUN: begin
        if (wd_expire)           st_nxt = S_FAULT;
        else if (stop)           st_nxt = S_STOPPING;
      end
      S_STOPPING: begin
        if (sync_pulse)          st_nxt = S_IDLE;
        else if (wd_expire)      st_nxt = S_FAULT;
      end
      S_FAULT: begin
        if (fault_clr)           st_nxt = S_IDLE;
      end
      default:                   st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      gen_enable   <= 1'b0;
      fault        <= 1'b0;
      cfg_err      <= 1'b0;
      arm_cnt      <= '0;
      wd_cnt       <= '0;
      gen_freq_div <= DIV_RST;
      shadow_div   <= '0;
      shadow_vld   <= 1'b0;
    end else begin
      st         <= st_nxt;
      gen_enable <= carrier_on_nxt;
      fault      <= (st_nxt == S_FAULT);
      cfg_err    <= cfg_acc && !cfg_legal;

      if ((st == S_IDLE) && (st_nxt == S_ARM))
        arm_cnt <= ARM_LOAD;
      else if ((st == S_ARM) && (arm_cnt != '0))
        arm_cnt <= arm_cnt - ARM_W'(1);

      // Watchdog only counts while the carrier is expected to be running.
      if ((st_nxt == S_RUN) && (st != S_RUN))
        wd_cnt <= '0;
      else if ((st == S_RUN) || (st == S_STOPPING))
        wd_cnt <= sync_pulse ? '0 : wd_inc;
      else
        wd_cnt <= '0;

      if ((st == S_IDLE) && cfg_acc && cfg_legal)
        gen_freq_div <= cfg_freq_div;
      else if ((st == S_RUN) && sync_pulse && shadow_vld)
        gen_freq_div <= shadow_div;

      // Shadow only survives while running or stopping; a STOPPING peak
      // lands in IDLE and therefore drops it.
      if (!carrier_on_nxt) begin
        shadow_vld <= 1'b0;
      end else if ((st == S_RUN) && sync_pulse && shadow_vld) begin
        shadow_vld <= 1'b0;
      end else if ((st == S_RUN) && cfg_acc && cfg_legal) begin
        shadow_vld <= 1'b1;
        shadow_div <= cfg_freq_div;
      end
    end
  end

endmodule

// File: tb/tb_pwm_carrier_sequencer.sv
module tb_pwm_carrier_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic [15:0] cfg_freq_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic        sync_pulse;
  logic        fault_clr;
  logic        gen_enable;
  logic [15:0] gen_freq_div;
  logic [2:0]  state;
  logic        fault;

  int errors = 0;
  int checks = 0;

  pwm_carrier_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_freq_div (cfg_freq_div),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .sync_pulse   (sync_pulse),
    .fault_clr    (fault_clr),
    .gen_enable   (gen_enable),
    .gen_freq_div (gen_freq_div),
    .state        (state),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; cfg_valid = 0; cfg_freq_div = '0;
    sync_pulse = 0; fault_clr = 0;
    step(); step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (gen_enable !== 1'b0) begin errors++; $display("FAIL reset_gen_enable: got %0b expected 0", gen_enable); end
    checks++; if (gen_freq_div !== 16'd10000) begin errors++; $display("FAIL reset_div: got %0d expected 10000", gen_freq_div); end
    checks++; if (fault !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got fault=%0b cfg_err=%0b expected 0 0", fault, cfg_err); end
    rst_n = 1'b1;
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_cfg_ready: got %0b expected 1", cfg_ready); end
  endtask

  task automatic test_start();
    start = 1;
    step();
    start = 0;
    checks++; if (state !== 3'd1 || gen_enable !== 1'b0) begin errors++; $display("FAIL arm_edge1: got state=%0d en=%0b expected 1 0", state, gen_enable); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL arm_cfg_ready: got %0b expected 0", cfg_ready); end
    for (int i = 2; i <= 4; i++) begin
      step();
      checks++; if (state !== 3'd1 || gen_enable !== 1'b0) begin errors++; $display("FAIL arm_edge%0d: got state=%0d en=%0b expected 1 0", i, state, gen_enable); end
    end
    step();
    checks++; if (state !== 3'd2 || gen_enable !== 1'b1) begin errors++; $display("FAIL run_entry: got state=%0d en=%0b expected 2 1", state, gen_enable); end
    checks++; if (gen_freq_div !== 16'd10000) begin errors++; $display("FAIL run_div: got %0d expected 10000", gen_freq_div); end
  endtask

  task automatic test_shadow();
    step(); step();
    cfg_valid = 1; cfg_freq_div = 16'd5000;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL shadow_ready_before: got %0b expected 1", cfg_ready); end
    step();
    cfg_valid = 0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL shadow_ready_drop: got %0b expected 0", cfg_ready); end
    step(); step(); step();
    checks++; if (gen_freq_div !== 16'd10000) begin errors++; $display("FAIL shadow_hold: got %0d expected 10000", gen_freq_div); end
    sync_pulse = 1;
    step();
    sync_pulse = 0;
    checks++; if (gen_freq_div !== 16'd5000) begin errors++; $display("FAIL shadow_apply: got %0d expected 5000", gen_freq_div); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL shadow_ready_back: got %0b expected 1", cfg_ready); end
    // divider accepted on a peak cycle waits for the following peak
    cfg_valid = 1; cfg_freq_div = 16'd100; sync_pulse = 1;
    step();
    cfg_valid = 0; sync_pulse = 0;
    checks++; if (gen_freq_div !== 16'd5000 || cfg_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_hold: got div=%0d rdy=%0b expected 5000 0", gen_freq_div, cfg_ready); end
    step();
    sync_pulse = 1;
    step();
    sync_pulse = 0;
    checks++; if (gen_freq_div !== 16'd100) begin errors++; $display("FAIL same_cycle_apply: got %0d expected 100", gen_freq_div); end
  endtask

  task automatic test_stop();
    stop = 1;
    step();
    stop = 0;
    checks++; if (state !== 3'd3 || gen_enable !== 1'b1) begin errors++; $display("FAIL stopping_entry: got state=%0d en=%0b expected 3 1", state, gen_enable); end
    start = 1; stop = 1;
    step(); step(); step();
    start = 0; stop = 0;
    checks++; if (state !== 3'd3 || gen_enable !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL stopping_hold: got state=%0d en=%0b rdy=%0b expected 3 1 0", state, gen_enable, cfg_ready); end
    sync_pulse = 1;
    step();
    sync_pulse = 0;
    checks++; if (state !== 3'd0 || gen_enable !== 1'b0) begin errors++; $display("FAIL stop_done: got state=%0d en=%0b expected 0 0", state, gen_enable); end
    checks++; if (gen_freq_div !== 16'd100) begin errors++; $display("FAIL stop_div: got %0d expected 100", gen_freq_div); end
  endtask

  task automatic test_reject();
    cfg_valid = 1; cfg_freq_div = 16'd1;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reject_ready: got %0b expected 1", cfg_ready); end
    step();
    cfg_valid = 0;
    checks++; if (cfg_err !== 1'b1 || gen_freq_div !== 16'd100) begin errors++; $display("FAIL reject_err: got err=%0b div=%0d expected 1 100", cfg_err, gen_freq_div); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reject_pulse_once: got %0b expected 0", cfg_err); end
    cfg_valid = 1; cfg_freq_div = 16'h00FF;
    step();
    cfg_valid = 0;
    checks++; if (gen_freq_div !== 16'h00FF || cfg_err !== 1'b0) begin errors++; $display("FAIL accept_ff: got div=%0h err=%0b expected ff 0", gen_freq_div, cfg_err); end
    cfg_valid = 1; cfg_freq_div = 16'd2;
    step();
    cfg_valid = 0;
    step();
    checks++; if (gen_freq_div !== 16'd2 || cfg_err !== 1'b0) begin errors++; $display("FAIL accept_min: got div=%0d err=%0b expected 2 0", gen_freq_div, cfg_err); end
    cfg_valid = 1; cfg_freq_div = 16'd100;
    step();
    cfg_valid = 0;
    checks++; if (gen_freq_div !== 16'd100) begin errors++; $display("FAIL accept_100: got %0d expected 100", gen_freq_div); end
  endtask

  task automatic test_idle_priority();
    start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL start_stop_idle: got state=%0d expected 0", state); end
    sync_pulse = 1;
    step();
    sync_pulse = 0;
    checks++; if (state !== 3'd0 || gen_enable !== 1'b0) begin errors++; $display("FAIL sync_idle: got state=%0d en=%0b expected 0 0", state, gen_enable); end
  endtask

  task automatic test_watchdog();
    start = 1;
    step();
    start = 0;
    repeat (4) step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL wd_run: got state=%0d expected 2", state); end
    sync_pulse = 1;
    step();
    sync_pulse = 0;
    repeat (208) step();
    checks++; if (fault !== 1'b0 || state !== 3'd2) begin errors++; $display("FAIL wd_208: got fault=%0b state=%0d expected 0 2", fault, state); end
    // peak on the expiry cycle rescues the carrier
    sync_pulse = 1;
    step();
    sync_pulse = 0;
    checks++; if (fault !== 1'b0 || state !== 3'd2) begin errors++; $display("FAIL wd_sync_wins: got fault=%0b state=%0d expected 0 2", fault, state); end
    repeat (208) step();
    checks++; if (fault !== 1'b0 || gen_enable !== 1'b1) begin errors++; $display("FAIL wd_pre_expiry: got fault=%0b en=%0b expected 0 1", fault, gen_enable); end
    step();
    checks++; if (fault !== 1'b1 || gen_enable !== 1'b0 || state !== 3'd4) begin errors++; $display("FAIL wd_expiry: got fault=%0b en=%0b state=%0d expected 1 0 4", fault, gen_enable, state); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL fault_cfg_ready: got %0b expected 0", cfg_ready); end
    start = 1; sync_pulse = 1;
    step();
    start = 0; sync_pulse = 0;
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL fault_sticky: got state=%0d expected 4", state); end
    fault_clr = 1;
    step();
    fault_clr = 0;
    checks++; if (state !== 3'd0 || fault !== 1'b0 || gen_freq_div !== 16'd100) begin errors++; $display("FAIL fault_clr: got state=%0d fault=%0b div=%0d expected 0 0 100", state, fault, gen_freq_div); end
    start = 1;
    step();
    start = 0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL rearm: got state=%0d expected 1", state); end
    repeat (4) step();
    checks++; if (state !== 3'd2 || gen_enable !== 1'b1) begin errors++; $display("FAIL rearm_run: got state=%0d en=%0b expected 2 1", state, gen_enable); end
  endtask

  task automatic test_reset_in_run();
    cfg_valid = 1; cfg_freq_div = 16'd300;
    step();
    cfg_valid = 0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pending_shadow: got rdy=%0b expected 0", cfg_ready); end
    rst_n = 0;
    #1;
    checks++; if (gen_enable !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL async_reset: got en=%0b state=%0d expected 0 0", gen_enable, state); end
    step(); step();
    rst_n = 1;
    step();
    checks++; if (gen_freq_div !== 16'd10000) begin errors++; $display("FAIL reset_div_restore: got %0d expected 10000", gen_freq_div); end
    start = 1;
    step();
    start = 0;
    repeat (4) step();
    checks++; if (state !== 3'd2 || cfg_ready !== 1'b1) begin errors++; $display("FAIL shadow_discarded: got state=%0d rdy=%0b expected 2 1", state, cfg_ready); end
    sync_pulse = 1;
    step();
    sync_pulse = 0;
    checks++; if (gen_freq_div !== 16'd10000) begin errors++; $display("FAIL no_stale_shadow: got %0d expected 10000", gen_freq_div); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_shadow();
    test_stop();
    test_reject();
    test_idle_priority();
    test_watchdog();
    test_reset_in_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
